// File: rtl/term_char_writer_if.sv
// term_char_writer_if: byte-stream handshake plus text buffer
// read/write ports of the terminal character writer.
interface term_char_writer_if;
  logic [7:0] char_in;
  logic       char_valid;
  logic       char_ready;
  logic       wr_en;
  logic [4:0] wr_row;
  logic [6:0] wr_col;
  logic [7:0] wr_data;
  logic [4:0] rd_row;
  logic [6:0] rd_col;
  logic [7:0] rd_data;

  modport master (
    input  char_in, char_valid, rd_data,
    output char_ready, wr_en, wr_row, wr_col,
    output wr_data, rd_row, rd_col
  );

  modport slave (
    output char_in, char_valid, rd_data,
    input  char_ready, wr_en, wr_row, wr_col,
    input  wr_data, rd_row, rd_col
  );
endinterface

// File: rtl/term_char_writer.sv
// term_char_writer: byte stream -> text buffer, cursor, scroll.
// Option: TERM_CHAR_WRITER_FORMFEED_EN (0x0C clears whole buffer).
module term_char_writer #(
  parameter int         ROWS  = 30,
  parameter int         COLS  = 80,
  parameter logic [7:0] BLANK = 8'h00,
  parameter bit         LF_CR = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  term_char_writer_if.master  bus,
  output logic [4:0]          cursor_row,
  output logic [6:0]          cursor_col,
  output logic                busy
);
  localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);
  localparam logic [6:0] LAST_COL = 7'(COLS - 1);

  typedef enum logic [2:0] {
    IDLE, SCROLL_RD, SCROLL_WR, CLR_LINE, CLR_ALL
  } state_t;

  state_t     state, state_d;
  logic [4:0] r, r_d, cur_row_d;
  logic [6:0] c, c_d, cur_col_d;
  logic       wr_en_q, wr_en_d;
  logic [4:0] wr_row_q, wr_row_d, rd_row_q, rd_row_d;
  logic [6:0] wr_col_q, wr_col_d, rd_col_q, rd_col_d;
  logic [7:0] wr_data_q, wr_data_d;
  logic       accept, is_cr, is_lf, is_bs, is_ff;
  logic       at_last_col, at_last_row;
  logic       row_inc, overflow, copy_last;

  assign accept = bus.char_valid && (state == IDLE);
  assign is_cr  = (bus.char_in == 8'h0D);
  assign is_lf  = (bus.char_in == 8'h0A);
  assign is_bs  = (bus.char_in == 8'h08);
`ifdef TERM_CHAR_WRITER_FORMFEED_EN
  assign is_ff  = (bus.char_in == 8'h0C);
`else
  assign is_ff  = 1'b0;
`endif

  assign at_last_col = (cursor_col == LAST_COL);
  assign at_last_row = (cursor_row == LAST_ROW);
  assign row_inc  = is_lf
                 || (!is_cr && !is_bs && !is_ff && at_last_col);
  assign overflow = row_inc && at_last_row;
  assign copy_last = (r == LAST_ROW - 5'd1)
                  && (c == LAST_COL);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE: begin
        if (accept && is_ff)         state_d = CLR_ALL;
        else if (accept && overflow) state_d = SCROLL_RD;
      end
      SCROLL_RD: state_d = SCROLL_WR;
      SCROLL_WR: state_d = copy_last ? CLR_LINE : SCROLL_RD;
      CLR_LINE:  if (c == LAST_COL) state_d = IDLE;
      CLR_ALL: begin
        if (r == LAST_ROW && c == LAST_COL) state_d = IDLE;
      end
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    r_d       = r;
    c_d       = c;
    cur_row_d = cursor_row;
    cur_col_d = cursor_col;
    wr_en_d   = 1'b0;
    wr_row_d  = wr_row_q;
    wr_col_d  = wr_col_q;
    wr_data_d = wr_data_q;
    rd_row_d  = rd_row_q;
    rd_col_d  = rd_col_q;
    unique case (state)
      IDLE: begin
        if (accept) begin
          r_d = '0;
          c_d = '0;
          unique case (1'b1)
            is_cr: cur_col_d = '0;
            is_lf: if (LF_CR) cur_col_d = '0;
            is_bs: begin
              if (cursor_col != '0)
                cur_col_d = cursor_col - 7'd1;
            end
            is_ff: begin
              cur_row_d = '0;
              cur_col_d = '0;
            end
            default: begin
              wr_en_d   = 1'b1;
              wr_row_d  = cursor_row;
              wr_col_d  = cursor_col;
              wr_data_d = bus.char_in;
              cur_col_d = at_last_col ? 7'd0
                                      : cursor_col + 7'd1;
            end
          endcase
          if (row_inc && !at_last_row)
            cur_row_d = cursor_row + 5'd1;
          if (overflow) begin
            rd_row_d = 5'd1;
            rd_col_d = '0;
          end
        end
      end
      SCROLL_RD: ;
      // rd_data now holds cell (r+1,c); it lands in row r
      SCROLL_WR: begin
        wr_en_d   = 1'b1;
        wr_row_d  = r;
        wr_col_d  = c;
        wr_data_d = bus.rd_data;
        if (c == LAST_COL) begin
          c_d = '0;
          r_d = r + 5'd1;
        end else begin
          c_d = c + 7'd1;
        end
        if (!copy_last) begin
          rd_row_d = r_d + 5'd1;
          rd_col_d = c_d;
        end
      end
      CLR_LINE: begin
        wr_en_d   = 1'b1;
        wr_row_d  = LAST_ROW;
        wr_col_d  = c;
        wr_data_d = BLANK;
        c_d       = c + 7'd1;
      end
      CLR_ALL: begin
        wr_en_d   = 1'b1;
        wr_row_d  = r;
        wr_col_d  = c;
        wr_data_d = BLANK;
        if (c == LAST_COL) begin
          c_d = '0;
          r_d = r + 5'd1;
        end else begin
          c_d = c + 7'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r          <= '0;
      c          <= '0;
      cursor_row <= '0;
      cursor_col <= '0;
      wr_en_q    <= 1'b0;
      wr_row_q   <= '0;
      wr_col_q   <= '0;
      wr_data_q  <= '0;
      rd_row_q   <= '0;
      rd_col_q   <= '0;
    end else begin
      r          <= r_d;
      c          <= c_d;
      cursor_row <= cur_row_d;
      cursor_col <= cur_col_d;
      wr_en_q    <= wr_en_d;
      wr_row_q   <= wr_row_d;
      wr_col_q   <= wr_col_d;
      wr_data_q  <= wr_data_d;
      rd_row_q   <= rd_row_d;
      rd_col_q   <= rd_col_d;
    end
  end

  assign bus.char_ready = (state == IDLE);
  assign busy           = (state != IDLE);
  assign bus.wr_en      = wr_en_q;
  assign bus.wr_row     = wr_row_q;
  assign bus.wr_col     = wr_col_q;
  assign bus.wr_data    = wr_data_q;
  assign bus.rd_row     = rd_row_q;
  assign bus.rd_col     = rd_col_q;
endmodule
